// File: rtl/bicubic_dual_mac.sv
// Bicubic dual-output MAC: 16-tap window times 16 packed dual coefficients, four-stage
// pipeline with global-stall flow control and coefficient-ROM line-select generation.
module bicubic_dual_mac #(
    parameter int PIX_W  = 8,
    parameter int COEF_W = 9,
    parameter int FRAC_W = 8
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic [16*PIX_W-1:0]      win_i,
    input  logic                     sof_i,
    input  logic                     eol_i,
    input  logic                     win_valid_i,
    output logic                     win_ready_o,
    output logic                     line_o,
    input  logic [16*2*COEF_W-1:0]   coeff_dsp_i,
    output logic [2*PIX_W-1:0]       pix_o,
    output logic                     sof_o,
    output logic                     eol_o,
    output logic                     pix_valid_o,
    input  logic                     pix_ready_i
);

    localparam int TAPS   = 16;
    localparam int WORD_W = 2 * COEF_W;
    localparam int PROD_W = PIX_W + COEF_W + 1;
    localparam int PSUM_W = PROD_W + 2;
    localparam int SUM_W  = PROD_W + 4;
    localparam logic signed [SUM_W-1:0] ROUND_C = {{(SUM_W-1){1'b0}}, 1'b1} << (FRAC_W - 1);

    function automatic logic signed [PROD_W-1:0] mul_tap(input logic [PIX_W-1:0] pix,
                                                         input logic [COEF_W-1:0] coef);
        logic signed [PROD_W-1:0] p_x;
        logic signed [PROD_W-1:0] c_x;
        p_x = {{(PROD_W-PIX_W){1'b0}}, pix};
        c_x = {{(PROD_W-COEF_W){coef[COEF_W-1]}}, coef};
        return p_x * c_x;
    endfunction

    function automatic logic signed [PSUM_W-1:0] ext_p(input logic signed [PROD_W-1:0] p);
        return {{(PSUM_W-PROD_W){p[PROD_W-1]}}, p};
    endfunction

    function automatic logic signed [SUM_W-1:0] ext_s(input logic signed [PSUM_W-1:0] p);
        return {{(SUM_W-PSUM_W){p[PSUM_W-1]}}, p};
    endfunction

    // Round to nearest, drop fraction bits, saturate into the unsigned pixel range.
    function automatic logic [PIX_W-1:0] round_clamp(input logic signed [SUM_W-1:0] sum);
        logic signed [SUM_W-1:0] shifted;
        shifted = (sum + ROUND_C) >>> FRAC_W;
        if (shifted[SUM_W-1]) begin
            return {PIX_W{1'b0}};
        end else if (|shifted[SUM_W-2:PIX_W]) begin
            return {PIX_W{1'b1}};
        end else begin
            return shifted[PIX_W-1:0];
        end
    endfunction

    logic                     en_s, accept_s, line_s;
    logic                     phase_q, phase_d;
    logic                     s1_valid_q, s1_sof_q, s1_eol_q, s1_line_q;
    logic [16*PIX_W-1:0]      s1_win_q;
    logic                     s2_valid_q, s2_sof_q, s2_eol_q;
    logic signed [PROD_W-1:0] s2_lo_q [TAPS];
    logic signed [PROD_W-1:0] s2_hi_q [TAPS];
    logic signed [PROD_W-1:0] prod_lo_d [TAPS];
    logic signed [PROD_W-1:0] prod_hi_d [TAPS];
    logic                     s3_valid_q, s3_sof_q, s3_eol_q;
    logic signed [PSUM_W-1:0] s3_lo_q [4];
    logic signed [PSUM_W-1:0] s3_hi_q [4];
    logic signed [PSUM_W-1:0] psum_lo_d [4];
    logic signed [PSUM_W-1:0] psum_hi_d [4];
    logic signed [SUM_W-1:0]  sum_lo_s, sum_hi_s;
    logic [PIX_W-1:0]         pix_lo_s, pix_hi_s;

    // Flow control, line phase and ROM line-select; a stall re-selects the stage-1 line.
    always_comb begin
        en_s        = !pix_valid_o || pix_ready_i;
        win_ready_o = en_s;
        accept_s    = win_valid_i && en_s;
        line_s      = sof_i ? 1'b0 : phase_q;
        line_o      = en_s ? line_s : s1_line_q;
        if (accept_s) begin
            phase_d = eol_i ? ~line_s : line_s;
        end else begin
            phase_d = phase_q;
        end
    end

    // Stage-2 products and stage-3 four-tap partial sums.
    always_comb begin
        for (int i = 0; i < TAPS; i++) begin
            prod_lo_d[i] = mul_tap(s1_win_q[i*PIX_W +: PIX_W], coeff_dsp_i[i*WORD_W +: COEF_W]);
            prod_hi_d[i] = mul_tap(s1_win_q[i*PIX_W +: PIX_W],
                                   coeff_dsp_i[i*WORD_W+COEF_W +: COEF_W]);
        end
        for (int g = 0; g < 4; g++) begin
            psum_lo_d[g] = ext_p(s2_lo_q[4*g]) + ext_p(s2_lo_q[4*g+1])
                         + ext_p(s2_lo_q[4*g+2]) + ext_p(s2_lo_q[4*g+3]);
            psum_hi_d[g] = ext_p(s2_hi_q[4*g]) + ext_p(s2_hi_q[4*g+1])
                         + ext_p(s2_hi_q[4*g+2]) + ext_p(s2_hi_q[4*g+3]);
        end
    end

    // Stage-4 final sum, rounding and clamp.
    always_comb begin
        sum_lo_s = ext_s(s3_lo_q[0]) + ext_s(s3_lo_q[1]) + ext_s(s3_lo_q[2]) + ext_s(s3_lo_q[3]);
        sum_hi_s = ext_s(s3_hi_q[0]) + ext_s(s3_hi_q[1]) + ext_s(s3_hi_q[2]) + ext_s(s3_hi_q[3]);
        pix_lo_s = round_clamp(sum_lo_s);
        pix_hi_s = round_clamp(sum_hi_s);
    end

    // Control state and registered outputs; outputs only reload when a real beat arrives.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            phase_q     <= 1'b0;
            s1_line_q   <= 1'b0;
            s1_valid_q  <= 1'b0;
            s2_valid_q  <= 1'b0;
            s3_valid_q  <= 1'b0;
            pix_valid_o <= 1'b0;
            pix_o       <= {(2*PIX_W){1'b0}};
            sof_o       <= 1'b0;
            eol_o       <= 1'b0;
        end else begin
            phase_q <= phase_d;
            if (en_s) begin
                s1_line_q   <= line_s;
                s1_valid_q  <= accept_s;
                s2_valid_q  <= s1_valid_q;
                s3_valid_q  <= s2_valid_q;
                pix_valid_o <= s3_valid_q;
                if (s3_valid_q) begin
                    pix_o <= {pix_hi_s, pix_lo_s};
                    sof_o <= s3_sof_q;
                    eol_o <= s3_eol_q;
                end
            end
        end
    end

    // Datapath registers; contents are qualified by the stage valids.
    always_ff @(posedge clk) begin
        if (en_s) begin
            s1_win_q <= win_i;
            s1_sof_q <= sof_i;
            s1_eol_q <= eol_i;
            s2_lo_q  <= prod_lo_d;
            s2_hi_q  <= prod_hi_d;
            s2_sof_q <= s1_sof_q;
            s2_eol_q <= s1_eol_q;
            s3_lo_q  <= psum_lo_d;
            s3_hi_q  <= psum_hi_d;
            s3_sof_q <= s2_sof_q;
            s3_eol_q <= s2_eol_q;
        end
    end

endmodule

// File: tb/tb_bicubic_dual_mac.sv
// Directed self-checking bench for bicubic_dual_mac with a registered coefficient-ROM model.
module tb_bicubic_dual_mac;

    logic         clk = 1'b0;
    logic         rstn = 1'b0;
    logic [127:0] win_i = 128'd0;
    logic         sof_i = 1'b0, eol_i = 1'b0, win_valid_i = 1'b0;
    logic         win_ready_o, line_o;
    logic [287:0] coeff_dsp_i = 288'd0;
    logic [15:0]  pix_o;
    logic         sof_o, eol_o, pix_valid_o;
    logic         pix_ready_i = 1'b0;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    logic [17:0] rom_words [2][16];

    logic        acc_line_q [$];
    int          acc_cyc_q  [$];
    logic [15:0] obs_pix_q  [$];
    logic        obs_sof_q  [$];
    logic        obs_eol_q  [$];
    int          obs_cyc_q  [$];
    int          stall_err = 0;
    int          line_err = 0;
    logic        prev_stall = 1'b0;
    logic [17:0] prev_out = 18'd0;
    logic        last_en_line = 1'b0;

    bicubic_dual_mac dut (
        .clk(clk), .rstn(rstn), .win_i(win_i), .sof_i(sof_i), .eol_i(eol_i),
        .win_valid_i(win_valid_i), .win_ready_o(win_ready_o), .line_o(line_o),
        .coeff_dsp_i(coeff_dsp_i), .pix_o(pix_o), .sof_o(sof_o), .eol_o(eol_o),
        .pix_valid_o(pix_valid_o), .pix_ready_i(pix_ready_i)
    );

    always #5 clk = ~clk;

    // Registered ROM: one-cycle latency from line_o.
    always @(posedge clk) begin
        for (int i = 0; i < 16; i++) coeff_dsp_i[i*18 +: 18] <= rom_words[line_o][i];
        cyc <= cyc + 1;
    end

    // Handshake recorder plus stall-stability and held-line watchers.
    always @(negedge clk) begin
        if (rstn) begin
            if (win_valid_i && win_ready_o) begin
                acc_line_q.push_back(line_o);
                acc_cyc_q.push_back(cyc);
            end
            if (pix_valid_o && pix_ready_i) begin
                obs_pix_q.push_back(pix_o);
                obs_sof_q.push_back(sof_o);
                obs_eol_q.push_back(eol_o);
                obs_cyc_q.push_back(cyc);
            end
            if (prev_stall && ({pix_o, sof_o, eol_o} !== prev_out)) stall_err <= stall_err + 1;
            if (!win_ready_o) begin
                if (line_o !== last_en_line) line_err <= line_err + 1;
            end else begin
                last_en_line <= line_o;
            end
            prev_stall <= pix_valid_o && !pix_ready_i;
            prev_out   <= {pix_o, sof_o, eol_o};
        end else begin
            prev_stall <= 1'b0;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired at cycle %0d, required finish earlier", cyc);
        $fatal(1);
    end

    function automatic logic [17:0] cw(input int hi, input int lo);
        return {hi[8:0], lo[8:0]};
    endfunction

    function automatic logic [15:0] model(input logic [127:0] w, input logic l);
        int slo, shi, rlo, rhi, p;
        logic signed [8:0] clo, chi;
        slo = 0;
        shi = 0;
        for (int i = 0; i < 16; i++) begin
            p   = int'(w[i*8 +: 8]);
            clo = rom_words[l][i][8:0];
            chi = rom_words[l][i][17:9];
            slo = slo + p * int'(clo);
            shi = shi + p * int'(chi);
        end
        rlo = (slo + 128) >>> 8;
        rhi = (shi + 128) >>> 8;
        if (rlo < 0) rlo = 0; else if (rlo > 255) rlo = 255;
        if (rhi < 0) rhi = 0; else if (rhi > 255) rhi = 255;
        return {rhi[7:0], rlo[7:0]};
    endfunction

    task automatic rom_fill(input logic [17:0] w0, input logic [17:0] w1, input logic [17:0] rest);
        for (int i = 0; i < 16; i++) begin
            rom_words[0][i] = (i == 0) ? w0 : rest;
            rom_words[1][i] = (i == 0) ? w1 : rest;
        end
    endtask

    task automatic clear_q();
        acc_line_q.delete(); acc_cyc_q.delete();
        obs_pix_q.delete(); obs_sof_q.delete(); obs_eol_q.delete(); obs_cyc_q.delete();
    endtask

    task automatic idle();
        win_valid_i = 1'b0; sof_i = 1'b0; eol_i = 1'b0;
    endtask

    task automatic send(input logic [127:0] w, input logic s, input logic e);
        int n;
        win_i = w; sof_i = s; eol_i = e; win_valid_i = 1'b1;
        n = 0;
        @(negedge clk);
        while (!win_ready_o && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (n >= 200) begin
            checks++; failures++;
            $display("FAIL send_timeout ready=%b required=1", win_ready_o);
        end
        @(posedge clk); #1;
    endtask

    task automatic wait_outs(input int n);
        int k;
        k = 0;
        while (obs_pix_q.size() < n && k < 300) begin
            @(posedge clk); #1;
            k++;
        end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (obs_pix_q.size() != n) begin
            failures++;
            $display("FAIL out_count got=%0d exp=%0d", obs_pix_q.size(), n);
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0; win_valid_i = 1'b1; win_i = {16{8'd200}}; pix_ready_i = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (pix_valid_o !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", pix_valid_o); end
        checks++; if (pix_o !== 16'd0) begin failures++; $display("FAIL reset_pix got=%h exp=0000", pix_o); end
        checks++; if (line_o !== 1'b0) begin failures++; $display("FAIL reset_line got=%b exp=0", line_o); end
        checks++; if (win_ready_o !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", win_ready_o); end
        @(posedge clk); #1;
        idle();
        rstn = 1'b1; pix_ready_i = 1'b1;
        clear_q();
        repeat (8) @(posedge clk);
        #1;
        checks++; if (obs_pix_q.size() != 0) begin failures++; $display("FAIL reset_no_output got=%0d exp=0", obs_pix_q.size()); end
    endtask

    task automatic test_single_tap();
        logic [127:0] w;
        rom_fill(cw(255, 128), cw(255, 128), 18'd0);
        clear_q();
        w = 128'd0; w[7:0] = 8'd201;
        send(w, 1'b1, 1'b0);
        w[7:0] = 8'd255;
        send(w, 1'b0, 1'b0);
        idle();
        wait_outs(2);
        if (obs_pix_q.size() >= 2 && acc_cyc_q.size() >= 2) begin
            checks++; if (obs_pix_q[0] !== {8'd200, 8'd101}) begin failures++; $display("FAIL tap_beat1 got=%h exp=c865", obs_pix_q[0]); end
            checks++; if (obs_pix_q[1] !== {8'd254, 8'd128}) begin failures++; $display("FAIL tap_beat2 got=%h exp=fe80", obs_pix_q[1]); end
            checks++; if (obs_cyc_q[0] - acc_cyc_q[0] != 4) begin failures++; $display("FAIL tap_latency got=%0d exp=4", obs_cyc_q[0] - acc_cyc_q[0]); end
            checks++; if (obs_cyc_q[1] - obs_cyc_q[0] != 1) begin failures++; $display("FAIL back_to_back_gap got=%0d exp=1", obs_cyc_q[1] - obs_cyc_q[0]); end
            checks++; if (obs_sof_q[0] !== 1'b1 || obs_sof_q[1] !== 1'b0) begin failures++; $display("FAIL tap_sof got=%b%b exp=10", obs_sof_q[0], obs_sof_q[1]); end
        end
    endtask

    task automatic test_clamp();
        rom_fill(cw(-64, 64), cw(64, -64), 18'd0);
        for (int i = 1; i < 16; i++) begin
            rom_words[0][i] = cw(-64, 64);
            rom_words[1][i] = cw(64, -64);
        end
        clear_q();
        send({16{8'd200}}, 1'b1, 1'b1);
        send({16{8'd200}}, 1'b0, 1'b0);
        idle();
        wait_outs(2);
        if (obs_pix_q.size() >= 2) begin
            checks++; if (obs_pix_q[0] !== 16'h00FF) begin failures++; $display("FAIL clamp_line0 got=%h exp=00ff", obs_pix_q[0]); end
            checks++; if (obs_pix_q[1] !== 16'hFF00) begin failures++; $display("FAIL clamp_sofeol_line1 got=%h exp=ff00", obs_pix_q[1]); end
        end
    endtask

    task automatic test_line_phase();
        logic [5:0] sofs, eols, lines;
        logic [127:0] w;
        sofs = 6'b100001; eols = 6'b010100; lines = 6'b011000;
        rom_fill(cw(0, 128), cw(0, 64), 18'd0);
        clear_q();
        w = 128'd0; w[7:0] = 8'd200;
        for (int i = 0; i < 6; i++) send(w, sofs[i], eols[i]);
        idle();
        wait_outs(6);
        if (obs_pix_q.size() >= 6 && acc_line_q.size() >= 6) begin
            for (int i = 0; i < 6; i++) begin
                checks++;
                if (acc_line_q[i] !== lines[i]) begin failures++; $display("FAIL phase_line[%0d] got=%b exp=%b", i, acc_line_q[i], lines[i]); end
                checks++;
                if (obs_pix_q[i] !== (lines[i] ? 16'h0032 : 16'h0064)) begin
                    failures++; $display("FAIL phase_pix[%0d] got=%h exp=%h", i, obs_pix_q[i], lines[i] ? 16'h0032 : 16'h0064);
                end
                checks++;
                if ({obs_sof_q[i], obs_eol_q[i]} !== {sofs[i], eols[i]}) begin
                    failures++; $display("FAIL phase_side[%0d] got=%b%b exp=%b%b", i, obs_sof_q[i], obs_eol_q[i], sofs[i], eols[i]);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        logic [127:0] ws [20];
        logic [15:0]  ep [20];
        logic         es [20], ee [20], el [20];
        logic         ph, l;
        int           idx, cnt, se0, le0;
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < 16; i++) rom_words[k][i] = 18'($urandom());
        ph = 1'b0;
        for (int i = 0; i < 20; i++) begin
            ws[i] = {$urandom(), $urandom(), $urandom(), $urandom()};
            es[i] = (i == 0) ? 1'b1 : ($urandom_range(0, 4) == 0);
            ee[i] = ($urandom_range(0, 3) == 0);
            l = es[i] ? 1'b0 : ph;
            ph = ee[i] ? ~l : l;
            el[i] = l;
            ep[i] = model(ws[i], l);
        end
        clear_q();
        se0 = stall_err; le0 = line_err;
        idx = 0; cnt = 0;
        while ((idx < 20 || obs_pix_q.size() < 20) && cnt < 2000) begin
            pix_ready_i = 1'($urandom_range(0, 1));
            if (idx < 20) begin
                win_i = ws[idx]; sof_i = es[idx]; eol_i = ee[idx]; win_valid_i = 1'b1;
            end else begin
                idle();
            end
            @(negedge clk);
            if (win_valid_i && win_ready_o) idx++;
            @(posedge clk); #1;
            cnt++;
        end
        idle();
        pix_ready_i = 1'b1;
        wait_outs(20);
        if (obs_pix_q.size() >= 20 && acc_line_q.size() >= 20) begin
            for (int i = 0; i < 20; i++) begin
                checks++;
                if ({obs_pix_q[i], obs_sof_q[i], obs_eol_q[i]} !== {ep[i], es[i], ee[i]}) begin
                    failures++; $display("FAIL bp_out[%0d] got=%h/%b%b exp=%h/%b%b", i, obs_pix_q[i], obs_sof_q[i], obs_eol_q[i], ep[i], es[i], ee[i]);
                end
                checks++;
                if (acc_line_q[i] !== el[i]) begin failures++; $display("FAIL bp_line[%0d] got=%b exp=%b", i, acc_line_q[i], el[i]); end
            end
        end
        checks++; if (stall_err != se0) begin failures++; $display("FAIL bp_stall_hold got=%0d exp=0 changes", stall_err - se0); end
        checks++; if (line_err != le0) begin failures++; $display("FAIL bp_line_hold got=%0d exp=0 mismatches", line_err - le0); end
    endtask

    task automatic test_mid_reset();
        logic [127:0] w;
        rom_fill(cw(0, 128), cw(0, 64), 18'd0);
        w = 128'd0; w[7:0] = 8'd200;
        clear_q();
        send(w, 1'b1, 1'b1);
        send(w, 1'b0, 1'b0);
        send(w, 1'b0, 1'b0);
        idle();
        rstn = 1'b0;
        @(posedge clk); #1;
        rstn = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        checks++; if (obs_pix_q.size() != 0) begin failures++; $display("FAIL midrst_flush got=%0d exp=0", obs_pix_q.size()); end
        clear_q();
        send(w, 1'b0, 1'b0);
        idle();
        wait_outs(1);
        if (obs_pix_q.size() >= 1 && acc_line_q.size() >= 1) begin
            checks++; if (acc_line_q[0] !== 1'b0) begin failures++; $display("FAIL midrst_line got=%b exp=0", acc_line_q[0]); end
            checks++; if (obs_pix_q[0] !== 16'h0064) begin failures++; $display("FAIL midrst_pix got=%h exp=0064", obs_pix_q[0]); end
        end
    endtask

    initial begin
        rom_fill(18'd0, 18'd0, 18'd0);
        test_reset();
        test_single_tap();
        test_clamp();
        test_line_phase();
        test_backpressure();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
